pong_game_seq: RTL and testbench
================================

Name: pong_game_seq

Overview:
- Game-flow sequencer for the Pong playfield logic.
- Decides whether the machine is in attract, serve-delay or live-play mode, and owns the two 4-bit score tallies.
- Detects a win and gates the ball/paddle datapath through registered mode outputs.
- Sits between the video timing chain (frame tick), the ball-position miss detectors and the score display.

Parameters:
- SERVE_FRAMES, 60, frame ticks spent in serve delay before the ball launches (legal range 1..255).
- WIN_SCORE, 11, score value that ends the game (legal range 1..15).
- ATTRACT_FRAMES, 180, frame ticks before auto-start (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is posedge.
- _clr  in  1  reset; asynchronous, active-low.
- frame_tick  in  1  one-clk pulse per video frame.
- coin  in  1  start request; level or pulse, sampled every clk.
- miss_l  in  1  one-clk pulse: ball exited the left edge (right player scores).
- miss_r  in  1  one-clk pulse: ball exited the right edge (left player scores).
- attract  out  1  high in ATTRACT.
- serve_wait  out  1  high in SERVE; the ball is held hidden at centre.
- play  out  1  high in PLAY; the ball datapath is enabled.
- serve_dir  out  1  launch direction (0 = toward left, 1 = toward right).
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- game_over  out  1  high from a win until the next game start.

Behaviour:
- Reset (_clr low, asynchronous): state = ATTRACT, attract = 1, serve_wait = 0, play = 0, serve_dir = 0, score_l = score_r = 0, game_over = 0, frame counter = 0.
- All outputs are registered and decoded from the next-state value, so they change in the same clk as the state register.
- States are ATTRACT, SERVE and PLAY.
- ATTRACT:
  - coin = 1 -> SERVE next clk.
  - On that transition: clear both scores, clear game_over, clear the frame counter, and keep serve_dir unchanged.
  - Scores and game_over otherwise hold, so the last game stays displayed.
- SERVE:
  - Each frame_tick increments the frame counter.
  - On the frame_tick where counter == SERVE_FRAMES-1 -> PLAY next clk.
  - Result: play rises 1 clk after the SERVE_FRAMES-th tick after entry.
  - miss_l, miss_r and coin are ignored in this state.
- PLAY, on miss_l:
  - score_r += 1.
  - serve_dir = 0 (the ball is served to the player who missed).
- PLAY, on miss_r:
  - score_l += 1.
  - serve_dir = 1.
- PLAY, after a scoring update:
  - If the new score == WIN_SCORE -> ATTRACT with game_over = 1.
  - Otherwise -> SERVE with the frame counter cleared.
- Simultaneous miss_l and miss_r: miss_l wins; only score_r increments and only one transition occurs.
- Scores saturate at 15. This is only reachable if WIN_SCORE > 15, which is illegal; the saturation is defensive.
- A coin in SERVE or PLAY is ignored; there is no restart mid-game.
- If frame_tick and a miss pulse arrive together in PLAY, the miss is processed and the tick is discarded.
- The frame counter is 8 bits and never wraps: it is cleared on every SERVE entry and the comparison uses ==.
- Reset mid-operation aborts any state immediately to the reset values; there is no pending-serve memory.

Optional Feature:
- Macro: PONG_SEQ_FREE_PLAY_EN.
- Defined:
  - In ATTRACT the frame counter counts frame_tick pulses.
  - When it reaches ATTRACT_FRAMES-1 on a tick, the block behaves exactly as if coin = 1 (auto-start).
  - coin still starts immediately.
  - The counter is cleared on ATTRACT entry.
- Undefined:
  - ATTRACT waits indefinitely for coin.
  - ATTRACT_FRAMES is unused.
  - The frame counter holds 0 in ATTRACT.

Decomposition:
- Package pong_seq_pkg holds:
  - state enum (ATTRACT, SERVE, PLAY), 2-bit encoding;
  - SCORE_W = 4;
  - FRAME_W = 8;
  - score saturation constant 15.
- One natural sub-module, pong_frame_timer:
  - 8-bit frame-tick counter with synchronous clear, enable and compare-to-limit;
  - done pulse output;
  - the same _clr reset.
- State register, score counters and serve_dir stay in pong_game_seq.

Test Plan:
- Reset/start: hold _clr low 3 clks, then release. Expected: attract = 1, scores 0/0, play = 0. Pulse coin. Expected: serve_wait = 1 next clk; after exactly 60 frame_ticks, play = 1 one clk after the 60th tick.
- Scoring and serve direction: in PLAY, pulse miss_r. Expected: score_l = 1, serve_dir = 1, serve_wait = 1. After 60 ticks play resumes. Pulse miss_l. Expected: score_r = 1, serve_dir = 0.
- Win: drive score_l to 10, then pulse miss_r. Expected: score_l = 11, game_over = 1, attract = 1. Pulse coin. Expected: scores 0/0, game_over = 0, serve_wait = 1.
- Simultaneous/ignored events: in PLAY, assert miss_l and miss_r together. Expected: score_r +1 only, score_l unchanged. Pulse coin and miss_r in SERVE. Expected: no change.
- Async reset mid-serve: in SERVE after 30 ticks, pulse _clr low mid-cycle. Expected: attract = 1 and scores 0 without a clk edge. Pulse coin. Expected: the full 60-tick delay is required again.
- Free play (PONG_SEQ_FREE_PLAY_EN defined): after reset with no coin. Expected: serve_wait = 1 one clk after the 180th frame_tick. Without the macro, no start occurs after 500 ticks.

Source files
------------

// File: rtl/pong_seq_pkg.sv
// Shared types and widths for the Pong game-flow sequencer.
// Optional free-play auto-start is enabled by PONG_SEQ_FREE_PLAY_EN.
package pong_seq_pkg;

    localparam int SCORE_W = 4;
    localparam int FRAME_W = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'd0,
        ST_SERVE   = 2'd1,
        ST_PLAY    = 2'd2
    } seq_state_e;

    // Scores stick at SCORE_MAX rather than wrapping back to zero.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-tick counter: synchronous clear, count enable and a done pulse
// asserted on the enabled tick where the count equals the limit.
module pong_frame_timer
    import pong_seq_pkg::*;
(
    input  logic               clk,
    input  logic               _clr,
    input  logic               clr,
    input  logic               en,
    input  logic [FRAME_W-1:0] limit,
    output logic               done
);

    logic [FRAME_W-1:0] count_reg;

    always_ff @(posedge clk or negedge _clr) begin
        if (!_clr) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign done = en && (count_reg == limit);

endmodule

// File: rtl/pong_game_seq.sv
// Pong game-flow sequencer: attract / serve-delay / live-play modes and scores.
// Define PONG_SEQ_FREE_PLAY_EN to auto-start after ATTRACT_FRAMES idle frames.
module pong_game_seq
    import pong_seq_pkg::*;
#(
    parameter int SERVE_FRAMES   = 60,
    parameter int WIN_SCORE      = 11,
    parameter int ATTRACT_FRAMES = 180
) (
    input  logic         clk,
    input  logic         _clr,
    input  logic         frame_tick,
    input  logic         coin,
    input  logic         miss_l,
    input  logic         miss_r,
    output logic         attract,
    output logic         serve_wait,
    output logic         play,
    output logic         serve_dir,
    output logic [3:0]   score_l,
    output logic [3:0]   score_r,
    output logic         game_over
);

    localparam logic [1:0] S_ATTRACT = ST_ATTRACT;
    localparam logic [1:0] S_SERVE   = ST_SERVE;
    localparam logic [1:0] S_PLAY    = ST_PLAY;

    localparam logic [FRAME_W-1:0] SERVE_LIM   = FRAME_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] ATTRACT_LIM = FRAME_W'(ATTRACT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL     = SCORE_W'(WIN_SCORE);

    logic [1:0]         state_reg, state_next;
    logic [SCORE_W-1:0] score_l_reg, score_l_next;
    logic [SCORE_W-1:0] score_r_reg, score_r_next;
    logic               serve_dir_reg, serve_dir_next;
    logic               game_over_reg, game_over_next;
    logic               attract_reg, serve_wait_reg, play_reg;

    logic               timer_clr, timer_en, timer_done, start, won;
    logic [FRAME_W-1:0] timer_limit;

    assign timer_limit = (state_reg == S_SERVE) ? SERVE_LIM : ATTRACT_LIM;

    pong_frame_timer u_timer (
        .clk   (clk),
        ._clr  (_clr),
        .clr   (timer_clr),
        .en    (timer_en),
        .limit (timer_limit),
        .done  (timer_done)
    );

    always_comb begin
        state_next     = state_reg;
        score_l_next   = score_l_reg;
        score_r_next   = score_r_reg;
        serve_dir_next = serve_dir_reg;
        game_over_next = game_over_reg;
        timer_clr      = 1'b0;
        timer_en       = 1'b0;
        start          = 1'b0;
        won            = 1'b0;
        case (state_reg)
            S_ATTRACT: begin
`ifdef PONG_SEQ_FREE_PLAY_EN
                timer_en = frame_tick;
                start    = coin | timer_done;
`else
                start    = coin;
`endif
                if (start) begin
                    state_next     = S_SERVE;
                    score_l_next   = '0;
                    score_r_next   = '0;
                    game_over_next = 1'b0;
                    timer_clr      = 1'b1;
                end
            end
            S_SERVE: begin
                timer_en = frame_tick;
                if (timer_done) begin
                    state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                // miss_l takes priority when both edges report a miss together
                if (miss_l) begin
                    score_r_next   = score_inc(score_r_reg);
                    serve_dir_next = 1'b0;
                    won            = (score_r_next == WIN_VAL);
                end else if (miss_r) begin
                    score_l_next   = score_inc(score_l_reg);
                    serve_dir_next = 1'b1;
                    won            = (score_l_next == WIN_VAL);
                end
                if (miss_l || miss_r) begin
                    timer_clr      = 1'b1;
                    game_over_next = won;
                    state_next     = won ? S_ATTRACT : S_SERVE;
                end
            end
            default: begin
                state_next = S_ATTRACT;
                timer_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _clr) begin
        if (!_clr) begin
            state_reg      <= S_ATTRACT;
            score_l_reg    <= '0;
            score_r_reg    <= '0;
            serve_dir_reg  <= 1'b0;
            game_over_reg  <= 1'b0;
            attract_reg    <= 1'b1;
            serve_wait_reg <= 1'b0;
            play_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            score_l_reg    <= score_l_next;
            score_r_reg    <= score_r_next;
            serve_dir_reg  <= serve_dir_next;
            game_over_reg  <= game_over_next;
            attract_reg    <= (state_next == S_ATTRACT);
            serve_wait_reg <= (state_next == S_SERVE);
            play_reg       <= (state_next == S_PLAY);
        end
    end

    assign attract    = attract_reg;
    assign serve_wait = serve_wait_reg;
    assign play       = play_reg;
    assign serve_dir  = serve_dir_reg;
    assign score_l    = score_l_reg;
    assign score_r    = score_r_reg;
    assign game_over  = game_over_reg;

endmodule

// File: tb/tb_pong_game_seq.sv
// Bench for pong_game_seq: vector table, corner-case sequences and a random
// run against a frame-counting reference model (honours PONG_SEQ_FREE_PLAY_EN).
module tb_pong_game_seq;

    localparam int SERVE_FRAMES   = 60;
    localparam int WIN_SCORE      = 11;
    localparam int ATTRACT_FRAMES = 180;

    logic       clk = 1'b0;
    logic       _clr = 1'b0;
    logic       frame_tick = 1'b0, coin = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
    logic       attract, serve_wait, play, serve_dir, game_over;
    logic [3:0] score_l, score_r;

    always #5 clk = ~clk;

    pong_game_seq #(
        .SERVE_FRAMES   (SERVE_FRAMES),
        .WIN_SCORE      (WIN_SCORE),
        .ATTRACT_FRAMES (ATTRACT_FRAMES)
    ) dut (
        .clk        (clk),
        ._clr       (_clr),
        .frame_tick (frame_tick),
        .coin       (coin),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .attract    (attract),
        .serve_wait (serve_wait),
        .play       (play),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over)
    );

    int errors = 0;
    int checks = 0;
    int games  = 0;

    // Reference model: mode 0 = attract, 1 = serve, 2 = play
    int   m_mode, m_ticks, m_sl, m_sr;
    logic m_dir, m_go;

    typedef struct {
        string      name;
        logic       tick, cn, ml, mr;
        int         reps;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] pack(input logic a, s, p, d, input int sl, sr, input logic go);
        return {a, s, p, d, 4'(sl), 4'(sr), go};
    endfunction

    function automatic logic [12:0] dut_out();
        return {attract, serve_wait, play, serve_dir, score_l, score_r, game_over};
    endfunction

    function automatic logic [12:0] model_out();
        return pack(m_mode == 0, m_mode == 1, m_mode == 2, m_dir, m_sl, m_sr, m_go);
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        checks++;
        if (dut_out() !== exp) begin
            errors++;
            $display("FAIL %s: got {a,s,p,d,sl,sr,go}=%b required %b", name, dut_out(), exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ticks = 0; m_sl = 0; m_sr = 0; m_dir = 1'b0; m_go = 1'b0;
    endtask

    task automatic model_step(input logic t, c, l, r);
        logic st;
        st = c;
        case (m_mode)
            0: begin
`ifdef PONG_SEQ_FREE_PLAY_EN
                if (t) begin
                    m_ticks++;
                    if (m_ticks == ATTRACT_FRAMES) st = 1'b1;
                end
`endif
                if (st) begin
                    m_mode = 1; m_sl = 0; m_sr = 0; m_go = 1'b0; m_ticks = 0;
                end
            end
            1: begin
                if (t) begin
                    m_ticks++;
                    if (m_ticks == SERVE_FRAMES) m_mode = 2;
                end
            end
            default: begin
                if (l || r) begin
                    if (l) begin
                        m_sr  = (m_sr < 15) ? m_sr + 1 : 15;
                        m_dir = 1'b0;
                    end else begin
                        m_sl  = (m_sl < 15) ? m_sl + 1 : 15;
                        m_dir = 1'b1;
                    end
                    m_ticks = 0;
                    if ((l && m_sr == WIN_SCORE) || (!l && m_sl == WIN_SCORE)) begin
                        m_mode = 0; m_go = 1'b1; games++;
                        $display("game %0d over: score %0d-%0d", games, m_sl, m_sr);
                    end else begin
                        m_mode = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic cycle(input logic t, c, l, r);
        frame_tick = t; coin = c; miss_l = l; miss_r = r;
        model_step(t, c, l, r);
        @(posedge clk);
        #1;
        frame_tick = 1'b0; coin = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    endtask

    task automatic cycles(input int n, input logic t, c, l, r);
        for (int i = 0; i < n; i++) cycle(t, c, l, r);
    endtask

    task automatic do_reset();
        _clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        _clr = 1'b1;
    endtask

    task automatic add(input string n, input logic t, c, l, r, input int reps, input logic [12:0] e);
        vec_t v;
        v.name = n; v.tick = t; v.cn = c; v.ml = l; v.mr = r; v.reps = reps; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        // reset held for three clocks, checked while asserted
        _clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", pack(1, 0, 0, 0, 0, 0, 0));
        _clr = 1'b1;

        //   name          tick coin ml mr reps  expected {a,s,p,dir,sl,sr,go}
        add("idle",        0, 0, 0, 0, 1,  pack(1, 0, 0, 0, 0, 0, 0));
        add("coin",        0, 1, 0, 0, 1,  pack(0, 1, 0, 0, 0, 0, 0));
        add("tick59",      1, 0, 0, 0, 59, pack(0, 1, 0, 0, 0, 0, 0));
        add("tick60",      1, 0, 0, 0, 1,  pack(0, 0, 1, 0, 0, 0, 0));
        add("miss_r",      0, 0, 0, 1, 1,  pack(0, 1, 0, 1, 1, 0, 0));
        add("serve_ign",   0, 1, 1, 1, 1,  pack(0, 1, 0, 1, 1, 0, 0));
        add("tick59b",     1, 0, 0, 0, 59, pack(0, 1, 0, 1, 1, 0, 0));
        add("tick60b",     1, 0, 0, 0, 1,  pack(0, 0, 1, 1, 1, 0, 0));
        add("miss_l",      0, 0, 1, 0, 1,  pack(0, 1, 0, 0, 1, 1, 0));
        add("serve60",     1, 0, 0, 0, 60, pack(0, 0, 1, 0, 1, 1, 0));
        add("miss_both",   0, 0, 1, 1, 1,  pack(0, 1, 0, 0, 1, 2, 0));
        add("serve60b",    1, 0, 0, 0, 60, pack(0, 0, 1, 0, 1, 2, 0));
        add("coin_play",   0, 1, 0, 0, 1,  pack(0, 0, 1, 0, 1, 2, 0));
        add("tick_play",   1, 0, 0, 0, 3,  pack(0, 0, 1, 0, 1, 2, 0));
        add("miss_tick",   1, 0, 0, 1, 1,  pack(0, 1, 0, 1, 2, 2, 0));

        foreach (vecs[i]) begin
            cycles(vecs[i].reps, vecs[i].tick, vecs[i].cn, vecs[i].ml, vecs[i].mr);
            $display("vec %0d %-10s reps=%0d out=%b", i, vecs[i].name, vecs[i].reps, dut_out());
            check(vecs[i].name, vecs[i].exp);
        end

        // bring score_l to 10, then the winning point
        for (int k = 0; k < 8; k++) begin
            cycles(SERVE_FRAMES, 1, 0, 0, 0);
            cycle(0, 0, 0, 1);
        end
        $display("seq score_to_10 out=%b", dut_out());
        check("score_to_10", pack(0, 1, 0, 1, 10, 2, 0));
        cycles(SERVE_FRAMES, 1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        $display("seq win out=%b", dut_out());
        check("win", pack(1, 0, 0, 1, 11, 2, 1));
        cycles(5, 0, 0, 0, 0);
        check("win_hold", pack(1, 0, 0, 1, 11, 2, 1));
        cycle(0, 1, 0, 0);
        $display("seq restart out=%b", dut_out());
        check("restart", pack(0, 1, 0, 1, 0, 0, 0));

        // asynchronous reset in the middle of a serve delay
        cycles(30, 1, 0, 0, 0);
        #2;
        _clr = 1'b0;
        #1;
        $display("seq async_clr out=%b", dut_out());
        check("async_clr", pack(1, 0, 0, 0, 0, 0, 0));
        model_reset();
        @(posedge clk);
        #1;
        _clr = 1'b1;
        cycle(0, 1, 0, 0);
        cycles(SERVE_FRAMES - 1, 1, 0, 0, 0);
        check("reserve59", pack(0, 1, 0, 0, 0, 0, 0));
        cycle(1, 0, 0, 0);
        $display("seq reserve out=%b", dut_out());
        check("reserve60", pack(0, 0, 1, 0, 0, 0, 0));

        // attract with no coin
        do_reset();
`ifdef PONG_SEQ_FREE_PLAY_EN
        cycles(ATTRACT_FRAMES - 1, 1, 0, 0, 0);
        check("free179", pack(1, 0, 0, 0, 0, 0, 0));
        cycle(1, 0, 0, 0);
        $display("seq free_play out=%b", dut_out());
        check("free180", pack(0, 1, 0, 0, 0, 0, 0));
`else
        cycles(500, 1, 0, 0, 0);
        $display("seq no_autostart out=%b", dut_out());
        check("no_autostart", pack(1, 0, 0, 0, 0, 0, 0));
`endif

        // random stimulus against the reference model
        do_reset();
        for (int i = 0; i < 12000; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 9) == 0));
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL rand cycle %0d: got %b required %b", i, dut_out(), model_out());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
